// File: rtl/reg_bank_pkg.sv
// Shared response type and helpers for the parametrised register bank.
// Widths are sized for the widest supported bank; callers cast to their own DATA_W.
package reg_bank_pkg;

    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] rdata;
        logic                  err;
        logic                  wr;
    } rsp_t;

    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_val,
        input logic [MAX_DATA_W-1:0] wdata,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_val;
        for (int k = 0; k < MAX_BE_W; k++) begin
            if (be[k]) begin
                merged[k*8 +: 8] = wdata[k*8 +: 8];
            end
        end
        return merged;
    endfunction

    function automatic logic addr_ok(
        input logic [31:0] addr,
        input int unsigned num_regs
    );
        return addr < num_regs;
    endfunction

endpackage

// File: rtl/reg_bank_rsp_slot.sv
// One-entry valid/ready response holding register; owns req_rdy and the rsp_* outputs.
// A new response may be loaded in the same cycle the current one is consumed.
module reg_bank_rsp_slot
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  rsp_t              push_rsp,
    input  logic              rsp_rdy,
    output logic              req_rdy,
    output logic              rsp_vld,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_wr
);

    logic vld_q;
    logic vld_d;
    rsp_t rsp_q;
    rsp_t rsp_d;

    assign req_rdy = !vld_q || rsp_rdy;

    always_comb begin
        vld_d = vld_q;
        rsp_d = rsp_q;
        if (push) begin
            vld_d = 1'b1;
            rsp_d = push_rsp;
        end else if (vld_q && rsp_rdy) begin
            vld_d = 1'b0;
            rsp_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            rsp_q <= '0;
        end else begin
            vld_q <= vld_d;
            rsp_q <= rsp_d;
        end
    end

    assign rsp_vld   = vld_q;
    assign rsp_rdata = rsp_q.rdata[DATA_W-1:0];
    assign rsp_err   = rsp_q.err;
    assign rsp_wr    = rsp_q.wr;

    // Bits above DATA_W are always zero-extended padding and never leave the block.
    if (DATA_W < MAX_DATA_W) begin : g_pad
        logic pad_unused;
        assign pad_unused = |rsp_q.rdata[MAX_DATA_W-1:DATA_W];
    end

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised register bank with byte strobes, read-only mask, range errors
// and a buffered valid/ready response path; all registers exported on reg_q.
module reg_bank_param
    import reg_bank_pkg::*;
#(
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 8,
    parameter int                  ADDR_W   = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter logic [DATA_W-1:0]   RST_VAL  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_vld,
    output logic                       req_rdy,
    input  logic                       req_wr,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W/8-1:0]        req_be,
    output logic                       rsp_vld,
    input  logic                       rsp_rdy,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       rsp_wr,
    output logic [NUM_REGS*DATA_W-1:0] reg_q
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] sel;
    logic                in_range;
    logic                sel_ro;
    logic                accept;
    logic                wr_hit;
    logic [DATA_W-1:0]   rd_data;
    rsp_t                rsp_d;

    assign accept   = req_vld && req_rdy;
    assign in_range = addr_ok(32'(req_addr), NUM_REGS);

    always_comb begin
        sel     = '0;
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel[i] = (req_addr == ADDR_W'(i));
            if (sel[i]) begin
                rd_data = regs_q[i];
            end
        end
    end

    assign sel_ro = |(sel & RO_MASK);
    assign wr_hit = accept && req_wr && in_range && !sel_ro;

    // Read-only registers are never selected for update, so they keep RST_VAL forever.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_hit && sel[i] && !RO_MASK[i]) begin
                regs_d[i] = DATA_W'(be_merge(MAX_DATA_W'(regs_q[i]),
                                             MAX_DATA_W'(req_wdata),
                                             MAX_BE_W'(req_be)));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rsp_d     = '0;
        rsp_d.wr  = req_wr;
        rsp_d.err = !in_range || (req_wr && sel_ro);
        if (!req_wr && in_range) begin
            rsp_d.rdata = MAX_DATA_W'(rd_data);
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    reg_bank_rsp_slot #(
        .DATA_W(DATA_W)
    ) u_rsp_slot (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_rsp (rsp_d),
        .rsp_rdy  (rsp_rdy),
        .req_rdy  (req_rdy),
        .rsp_vld  (rsp_vld),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .rsp_wr   (rsp_wr)
    );

endmodule

// File: tb/tb_reg_bank_param.sv
// Self-checking bench for reg_bank_param: directed vector table, hand-written
// backpressure/reset sequences, then randomized traffic against a queue-based model.
module tb_reg_bank_param;

    localparam int                  DATA_W   = 32;
    localparam int                  NUM_REGS = 8;
    localparam int                  ADDR_W   = 4;
    localparam int                  BE_W     = DATA_W / 8;
    localparam int                  BANK_W   = NUM_REGS * DATA_W;
    localparam logic [NUM_REGS-1:0] RO_MASK  = 8'h02;
    localparam logic [DATA_W-1:0]   RST_VAL  = 32'h0000_0000;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_vld;
    logic                req_rdy;
    logic                req_wr;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [BE_W-1:0]     req_be;
    logic                rsp_vld;
    logic                rsp_rdy;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                rsp_wr;
    logic [BANK_W-1:0]   reg_q;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              wr;
    } exp_rsp_t;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_err;
    } vec_t;

    logic [DATA_W-1:0] model_regs [NUM_REGS];
    logic [NUM_REGS-1:0] ro_mask_v;
    exp_rsp_t exp_q[$];
    vec_t vecs[$];

    reg_bank_param #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .RO_MASK (RO_MASK),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .rsp_wr   (rsp_wr),
        .reg_q    (reg_q)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkBank(input string name, input logic [BANK_W-1:0] actual,
                             input logic [BANK_W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic wr, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be,
                                 input logic rdy);
        req_vld   = vld;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_rdy   = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                           input logic [BE_W-1:0] be, input logic [DATA_W-1:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // Behavioural view of one access: range check, read-only check, byte-wise update.
    task automatic model_access(input logic wr, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be,
                                output exp_rsp_t r);
        int a;
        a = int'(addr);
        r.rdata = '0;
        r.err   = 1'b0;
        r.wr    = wr;
        if (a >= NUM_REGS) begin
            r.err = 1'b1;
        end else if (wr) begin
            if (ro_mask_v[a]) begin
                r.err = 1'b1;
            end else begin
                for (int k = 0; k < BE_W; k++) begin
                    if (be[k]) model_regs[a][k*8 +: 8] = wdata[k*8 +: 8];
                end
            end
        end else begin
            r.rdata = model_regs[a];
        end
    endtask

    function automatic logic [BANK_W-1:0] model_bank();
        logic [BANK_W-1:0] b;
        for (int i = 0; i < NUM_REGS; i++) b[i*DATA_W +: DATA_W] = model_regs[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = RST_VAL;
        exp_q.delete();
    endtask

    initial begin
        exp_rsp_t r;
        logic cur_vld, cur_wr, cur_rdy, exp_rdy, hold;
        logic [ADDR_W-1:0] cur_addr;
        logic [DATA_W-1:0] cur_wdata;
        logic [BE_W-1:0]   cur_be;

        ro_mask_v = RO_MASK;
        model_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        checkOutput("reset rsp_vld",   32'(rsp_vld),   32'(0));
        checkOutput("reset rsp_rdata", rsp_rdata,       32'h0);
        checkOutput("reset rsp_err",   32'(rsp_err),   32'(0));
        checkOutput("reset rsp_wr",    32'(rsp_wr),    32'(0));
        checkOutput("reset req_rdy",   32'(req_rdy),   32'(1));
        checkBank("reset reg_q", reg_q, {NUM_REGS{RST_VAL}});

        for (int a = 0; a < NUM_REGS; a++) add_vec(1'b0, ADDR_W'(a), '0, '0, 32'h0, 1'b0);
        add_vec(1'b1, 4'd2,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
        add_vec(1'b1, 4'd2,  32'h11223344, 4'h5, 32'h0,        1'b0);
        add_vec(1'b0, 4'd2,  32'h0,        4'h0, 32'hDE22BE44, 1'b0);
        add_vec(1'b1, 4'd1,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1);
        add_vec(1'b0, 4'd1,  32'h0,        4'h0, 32'h0,        1'b0);
        add_vec(1'b0, 4'd9,  32'h0,        4'h0, 32'h0,        1'b1);
        add_vec(1'b1, 4'd9,  32'h12345678, 4'hF, 32'h0,        1'b1);
        add_vec(1'b1, 4'd3,  32'hA5A5A5A5, 4'hF, 32'h0,        1'b0);
        add_vec(1'b1, 4'd4,  32'hCAFEF00D, 4'h0, 32'h0,        1'b0);
        add_vec(1'b0, 4'd4,  32'h0,        4'h0, 32'h0,        1'b0);
        add_vec(1'b0, 4'd3,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0);
        add_vec(1'b1, 4'd6,  32'h99887766, 4'h1, 32'h0,        1'b0);
        add_vec(1'b0, 4'd6,  32'h0,        4'h0, 32'h00000066, 1'b0);
        add_vec(1'b0, 4'd15, 32'h0,        4'h0, 32'h0,        1'b1);

        // Back-to-back with rsp_rdy held high: one accepted request per cycle.
        foreach (vecs[i]) begin
            applyStimulus(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b1);
            model_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, r);
            #1;
            checkOutput($sformatf("vec%0d req_rdy", i), 32'(req_rdy), 32'(1));
            tick();
            checkOutput($sformatf("vec%0d rsp_vld", i),   32'(rsp_vld), 32'(1));
            checkOutput($sformatf("vec%0d rsp_rdata", i), rsp_rdata,    vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d rsp_err", i),   32'(rsp_err), 32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d rsp_wr", i),    32'(rsp_wr),  32'(vecs[i].wr));
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        tick();
        checkOutput("drain rsp_vld", 32'(rsp_vld), 32'(0));
        checkOutput("reg2 via reg_q", reg_q[95:64], 32'hDE22BE44);
        checkOutput("reg1 RO via reg_q", reg_q[63:32], 32'h0);
        checkBank("table reg_q", reg_q, model_bank());

        // Backpressure: response for addr 3 must sit stable while rsp_rdy is low.
        applyStimulus(1'b1, 1'b0, 4'd3, '0, '0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 4'd2, '0, '0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("stall%0d req_rdy", c), 32'(req_rdy), 32'(0));
            checkOutput($sformatf("stall%0d rsp_vld", c), 32'(rsp_vld), 32'(1));
            checkOutput($sformatf("stall%0d rsp_rdata", c), rsp_rdata, 32'hA5A5A5A5);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 4'd2, '0, '0, 1'b1);
        #1;
        checkOutput("release req_rdy", 32'(req_rdy), 32'(1));
        tick();
        checkOutput("release rsp_vld", 32'(rsp_vld), 32'(1));
        checkOutput("release rsp_rdata", rsp_rdata, 32'hDE22BE44);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        tick();
        checkOutput("release drain", 32'(rsp_vld), 32'(0));

        // Reset while a write response is pending discards it at once.
        applyStimulus(1'b1, 1'b1, 4'd5, 32'h55AA55AA, 4'hF, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
        checkOutput("pre-rst rsp_vld", 32'(rsp_vld), 32'(1));
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst rsp_vld", 32'(rsp_vld), 32'(0));
        checkOutput("async rst rsp_wr",  32'(rsp_wr),  32'(0));
        checkBank("async rst reg_q", reg_q, {NUM_REGS{RST_VAL}});
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        applyStimulus(1'b1, 1'b0, 4'd2, '0, '0, 1'b1);
        tick();
        checkOutput("post-rst rsp_vld", 32'(rsp_vld), 32'(1));
        checkOutput("post-rst rsp_rdata", rsp_rdata, RST_VAL);
        checkOutput("post-rst rsp_err", 32'(rsp_err), 32'(0));
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        tick();

        // Randomized traffic with random backpressure against the queue model.
        hold = 1'b0;
        cur_vld = 1'b0; cur_wr = 1'b0; cur_addr = '0; cur_wdata = '0; cur_be = '0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                cur_vld   = ($urandom_range(0, 3) != 0);
                cur_wr    = 1'($urandom_range(0, 1));
                cur_addr  = ADDR_W'($urandom_range(0, 11));
                cur_wdata = $urandom;
                cur_be    = BE_W'($urandom);
            end
            cur_rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(cur_vld, cur_wr, cur_addr, cur_wdata, cur_be, cur_rdy);
            #1;
            exp_rdy = (exp_q.size() == 0) || cur_rdy;
            checkOutput("rnd req_rdy", 32'(req_rdy), 32'(exp_rdy));
            @(posedge clk);
            if (exp_q.size() != 0 && cur_rdy) void'(exp_q.pop_front());
            if (cur_vld && exp_rdy) begin
                model_access(cur_wr, cur_addr, cur_wdata, cur_be, r);
                exp_q.push_back(r);
                hold = 1'b0;
            end else begin
                hold = cur_vld;
            end
            #1;
            checkOutput("rnd rsp_vld", 32'(rsp_vld), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                checkOutput("rnd rsp_rdata", rsp_rdata, exp_q[0].rdata);
                checkOutput("rnd rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
                checkOutput("rnd rsp_wr", 32'(rsp_wr), 32'(exp_q[0].wr));
            end
            checkBank("rnd reg_q", reg_q, model_bank());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
